bus_phase_sequencer: RTL and testbench

BUS_PHASE_SEQUENCER -- requirements
Module: bus_phase_sequencer

---
 rtl/bus_seq_pkg.sv | 45 ++++
 rtl/wait_timer.sv | 38 +++
 rtl/bus_phase_sequencer.sv | 128 ++++++++++++
 tb/tb_bus_phase_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - shared types and encodings for the bus phase sequencer
package bus_seq_pkg;

    localparam int unsigned WAIT_MAX_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_LO   = 2'd0,
        ST_HI   = 2'd1,
        ST_CTRL = 2'd2,
        ST_WAIT = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_ADDR_LO   = 2'd0;
    localparam logic [1:0] SEL_ADDR_HI   = 2'd1;
    localparam logic [1:0] SEL_CTRL      = 2'd2;
    localparam logic [1:0] SEL_CTRL_WAIT = 2'd3;

    localparam int unsigned CTRL_BIT_RW   = 0;
    localparam int unsigned CTRL_BIT_SYNC = 1;
    localparam int unsigned CTRL_BIT_CLK  = 2;
    localparam int unsigned CTRL_BIT_WAIT = 3;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic        sync;
    } shadow_t;

    // Upper nibble of the control byte is always zero.
    function automatic logic [7:0] ctrl_byte(
        input logic rw,
        input logic sync,
        input logic clk_level,
        input logic wait_flag
    );
        logic [7:0] b;
        b = 8'h00;
        b[CTRL_BIT_RW]   = rw;
        b[CTRL_BIT_SYNC] = sync;
        b[CTRL_BIT_CLK]  = clk_level;
        b[CTRL_BIT_WAIT] = wait_flag;
        return b;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating wait-state counter with timeout compare
module wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic increment,
    output logic expired
);

    localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturates at LAST so the count can never wrap back into range.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (increment && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/bus_phase_sequencer.sv
// rtl/bus_phase_sequencer.sv - multiplexed address/control bus phase sequencer with CPU clock generation
module bus_phase_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic        cpu_sync,
    input  logic        ext_wait,
    output logic        cpu_clk,
    output logic [7:0]  mux_out,
    output logic [1:0]  mux_sel,
    output logic        cpu_clk_fall,
    output logic        wait_timeout
);

    seq_state_t state_q, state_d;
    shadow_t    shadow_q, shadow_d;
    logic       cpu_clk_q, cpu_clk_d;
    logic [7:0] mux_out_q, mux_out_d;
    logic [1:0] mux_sel_q, mux_sel_d;
    logic       clk_fall_q, clk_fall_d;
    logic       timeout_q, timeout_d;

    logic       wt_clear;
    logic       wt_inc;
    logic       wt_expired;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (wt_clear),
        .increment (wt_inc),
        .expired   (wt_expired)
    );

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        cpu_clk_d  = cpu_clk_q;
        mux_out_d  = mux_out_q;
        mux_sel_d  = mux_sel_q;
        clk_fall_d = 1'b0;
        timeout_d  = 1'b0;
        wt_clear   = 1'b0;
        wt_inc     = 1'b0;

        if (ena) begin
            case (state_q)
                ST_LO: begin
                    // Whole address captured at once so the hi byte can't tear.
                    shadow_d.addr = cpu_addr;
                    shadow_d.rw   = cpu_rw;
                    shadow_d.sync = cpu_sync;
                    mux_out_d     = cpu_addr[7:0];
                    mux_sel_d     = SEL_ADDR_LO;
                    state_d       = ST_HI;
                end
                ST_HI: begin
                    mux_out_d = shadow_q.addr[15:8];
                    mux_sel_d = SEL_ADDR_HI;
                    state_d   = ST_CTRL;
                end
                ST_CTRL: begin
                    mux_out_d = ctrl_byte(shadow_q.rw, shadow_q.sync, cpu_clk_q, 1'b0);
                    mux_sel_d = SEL_CTRL;
                    // Wait requests only stretch the high phase.
                    if (cpu_clk_q && ext_wait) begin
                        wt_clear = 1'b1;
                        state_d  = ST_WAIT;
                    end else begin
                        cpu_clk_d  = ~cpu_clk_q;
                        clk_fall_d = cpu_clk_q;
                        state_d    = ST_LO;
                    end
                end
                ST_WAIT: begin
                    mux_out_d = ctrl_byte(shadow_q.rw, shadow_q.sync, cpu_clk_q, 1'b1);
                    mux_sel_d = SEL_CTRL_WAIT;
                    if (!ext_wait || wt_expired) begin
                        cpu_clk_d  = 1'b0;
                        clk_fall_d = cpu_clk_q;
                        timeout_d  = ext_wait;
                        state_d    = ST_LO;
                    end else begin
                        wt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LO;
            shadow_q   <= '0;
            cpu_clk_q  <= 1'b0;
            mux_out_q  <= 8'h00;
            mux_sel_q  <= SEL_ADDR_LO;
            clk_fall_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            cpu_clk_q  <= cpu_clk_d;
            mux_out_q  <= mux_out_d;
            mux_sel_q  <= mux_sel_d;
            clk_fall_q <= clk_fall_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cpu_clk      = cpu_clk_q;
    assign mux_out      = mux_out_q;
    assign mux_sel      = mux_sel_q;
    assign cpu_clk_fall = clk_fall_q;
    assign wait_timeout = timeout_q;

endmodule

// File: tb/tb_bus_phase_sequencer.sv
// tb/tb_bus_phase_sequencer.sv - self-checking bench for bus_phase_sequencer
module tb_bus_phase_sequencer;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        cpu_sync;
    logic        ext_wait;
    logic        cpu_clk;
    logic [7:0]  mux_out;
    logic [1:0]  mux_sel;
    logic        cpu_clk_fall;
    logic        wait_timeout;

    bus_phase_sequencer #(
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_sync     (cpu_sync),
        .ext_wait     (ext_wait),
        .cpu_clk      (cpu_clk),
        .mux_out      (mux_out),
        .mux_sel      (mux_sel),
        .cpu_clk_fall (cpu_clk_fall),
        .wait_timeout (wait_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a bus cycle is three byte slots (lo, hi, control);
    // a control slot with the clock high and wait requested opens a stretch
    // of wait slots that ends on release or after WAIT_MAX slots.
    int          m_slot;
    bit          m_waiting;
    int          m_waits;
    bit          m_clk;
    logic [7:0]  m_out;
    int          m_sel;
    bit          m_fall;
    bit          m_to;
    logic [15:0] m_addr;
    bit          m_rw;
    bit          m_sync;

    int hi_run;
    int last_hi;
    int n_timeouts;

    function automatic logic [7:0] ctrl_val(input bit w);
        return 8'(int'(m_rw) + 2 * int'(m_sync) + 4 * int'(m_clk) + 8 * int'(w));
    endfunction

    task automatic model_reset();
        m_slot = 0; m_waiting = 0; m_waits = 0; m_clk = 0;
        m_out = 8'h00; m_sel = 0; m_fall = 0; m_to = 0;
        m_addr = 16'h0000; m_rw = 0; m_sync = 0;
    endtask

    task automatic model_edge();
        m_fall = 0;
        m_to   = 0;
        if (ena) begin
            if (m_waiting) begin
                m_out = ctrl_val(1'b1);
                m_sel = 3;
                if (!ext_wait || m_waits == WAIT_MAX - 1) begin
                    m_fall = m_clk;
                    m_to = ext_wait;
                    m_clk = 0;
                    m_waiting = 0;
                    m_slot = 0;
                end else begin
                    m_waits++;
                end
            end else if (m_slot == 0) begin
                m_addr = cpu_addr; m_rw = cpu_rw; m_sync = cpu_sync;
                m_out = cpu_addr % 256;
                m_sel = 0;
                m_slot = 1;
            end else if (m_slot == 1) begin
                m_out = m_addr / 256;
                m_sel = 1;
                m_slot = 2;
            end else begin
                m_out = ctrl_val(1'b0);
                m_sel = 2;
                if (m_clk && ext_wait) begin
                    m_waiting = 1;
                    m_waits = 0;
                end else begin
                    m_fall = m_clk;
                    m_clk = !m_clk;
                    m_slot = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check_eq({ctx, ".cpu_clk"}, 16'(cpu_clk), 16'(m_clk));
        check_eq({ctx, ".mux_out"}, 16'(mux_out), 16'(m_out));
        check_eq({ctx, ".mux_sel"}, 16'(mux_sel), 16'(m_sel));
        check_eq({ctx, ".clk_fall"}, 16'(cpu_clk_fall), 16'(m_fall));
        check_eq({ctx, ".timeout"}, 16'(wait_timeout), 16'(m_to));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all("step");
        if (wait_timeout) n_timeouts++;
        if (cpu_clk) begin
            hi_run++;
        end else if (hi_run != 0) begin
            last_hi = hi_run;
            hi_run = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        hi_run = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_high_lo();
        ext_wait = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_clk && m_slot == 0 && !m_waiting) break;
            step();
        end
        check_eq("goto_high_lo", 16'(cpu_clk), 16'd1);
    endtask

    int n_sel3;
    int to_base;

    initial begin
        rst = 1'b1; ena = 1'b0; cpu_addr = 16'h0000; cpu_rw = 1'b0;
        cpu_sync = 1'b0; ext_wait = 1'b0;
        hi_run = 0; last_hi = 0; n_timeouts = 0;
        do_reset();
        check_eq("rst_mux_out", 16'(mux_out), 16'h00);
        check_eq("rst_sel", 16'(mux_sel), 16'd0);
        check_eq("rst_cpu_clk", 16'(cpu_clk), 16'd0);

        // Basic cycle: lo, hi, control, then nominal 3/3 clock phases.
        ena = 1'b1; cpu_addr = 16'hA55A; cpu_rw = 1'b1; cpu_sync = 1'b1;
        step();
        check_eq("seq_lo", 16'(mux_out), 16'h5A);
        step();
        check_eq("seq_hi", 16'(mux_out), 16'hA5);
        check_eq("seq_hi_sel", 16'(mux_sel), 16'd1);
        step();
        check_eq("seq_ctrl_first", 16'(mux_out), 16'h03);
        check_eq("seq_ctrl_sel", 16'(mux_sel), 16'd2);
        check_eq("seq_clk_rise", 16'(cpu_clk), 16'd1);
        begin
            int hi_len, lo_len;
            hi_len = 0;
            for (int i = 0; i < 20; i++) begin
                step(); hi_len++;
                if (!cpu_clk) break;
            end
            check_eq("seq_ctrl_high", 16'(mux_out), 16'h07);
            check_eq("seq_fall_pulse", 16'(cpu_clk_fall), 16'd1);
            check_eq("seq_high_len", 16'(hi_len), 16'd3);
            lo_len = 0;
            for (int i = 0; i < 20; i++) begin
                step(); lo_len++;
                if (cpu_clk) break;
            end
            check_eq("seq_low_len", 16'(lo_len), 16'd3);
        end

        // Address changes after the lo slot must not leak into the hi byte.
        cpu_addr = 16'h1234;
        step();
        cpu_addr = 16'hFFFF;
        step();
        check_eq("no_tear_hi", 16'(mux_out), 16'h12);
        step();

        // Four-slot wait stretch released by ext_wait.
        goto_high_lo();
        to_base = n_timeouts;
        step(); step();
        ext_wait = 1'b1;
        step();
        n_sel3 = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mux_sel == 2'd3 && mux_out[3]) n_sel3++;
        end
        ext_wait = 1'b0;
        step();
        if (mux_sel == 2'd3 && mux_out[3]) n_sel3++;
        check_eq("wait_sel3_cnt", 16'(n_sel3), 16'd4);
        check_eq("wait_fall", 16'(cpu_clk_fall), 16'd1);
        check_eq("wait_high_len", 16'(last_hi), 16'd7);
        check_eq("wait_no_timeout", 16'(n_timeouts - to_base), 16'd0);

        // Wait held forever: forced release after WAIT_MAX slots.
        goto_high_lo();
        to_base = n_timeouts;
        step(); step();
        ext_wait = 1'b1;
        step();
        n_sel3 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mux_sel == 2'd3) n_sel3++;
            if (!cpu_clk) break;
        end
        check_eq("timeout_sel3_cnt", 16'(n_sel3), 16'(WAIT_MAX));
        check_eq("timeout_pulse", 16'(wait_timeout), 16'd1);
        check_eq("timeout_cpu_clk", 16'(cpu_clk), 16'd0);
        check_eq("timeout_once", 16'(n_timeouts - to_base), 16'd1);
        check_eq("timeout_high_len", 16'(last_hi), 16'(3 + WAIT_MAX));
        ext_wait = 1'b0;

        // Freeze after the hi slot, then resume at the control slot.
        cpu_addr = 16'hC3E1;
        step();
        step();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_addr = 16'($urandom);
            ext_wait = 1'($urandom);
            step();
            check_eq("freeze_sel", 16'(mux_sel), 16'd1);
            check_eq("freeze_mux", 16'(mux_out), 16'hC3);
        end
        ena = 1'b1; ext_wait = 1'b0;
        step();
        check_eq("resume_ctrl_sel", 16'(mux_sel), 16'd2);

        // Reset in the middle of a wait stretch.
        goto_high_lo();
        step(); step();
        ext_wait = 1'b1;
        step(); step(); step();
        check_eq("pre_rst_in_wait", 16'(mux_sel), 16'd3);
        do_reset();
        check_eq("midwait_rst_clk", 16'(cpu_clk), 16'd0);
        check_eq("midwait_rst_mux", 16'(mux_out), 16'h00);
        check_eq("midwait_rst_sel", 16'(mux_sel), 16'd0);
        ext_wait = 1'b0; cpu_addr = 16'hBEEF;
        step();
        check_eq("post_rst_lo", 16'(mux_out), 16'hEF);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(149) == 0) do_reset();
            ena      = ($urandom_range(9) != 0);
            cpu_addr = 16'($urandom);
            cpu_rw   = 1'($urandom);
            cpu_sync = 1'($urandom);
            if ($urandom_range(4) == 0) ext_wait = !ext_wait;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
